// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multi-cycle MIPS control slice.
// Holds the opcode/funct encodings, the controller state enum, the codes
// driven on the pc_sel/rf_dst/rf_src/alu_op selects, and the bit positions
// of the one-hot instruction-class vector produced by mc_decode.
package mc_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field IR[5:0] for R-type
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Next-PC select
  localparam logic [1:0] PC_SEQ = 2'd0;  // pc+4
  localparam logic [1:0] PC_BR  = 2'd1;  // branch target
  localparam logic [1:0] PC_JMP = 2'd2;  // jump target
  localparam logic [1:0] PC_JR  = 2'd3;  // rs

  // Register-file write address select
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;  // $31

  // Register-file write data select
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MDR = 2'd1;
  localparam logic [1:0] SRC_PC  = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // Instruction-class one-hot bit positions
  localparam int CLS_ADDU    = 0;
  localparam int CLS_SUBU    = 1;
  localparam int CLS_JR      = 2;
  localparam int CLS_ORI     = 3;
  localparam int CLS_LUI     = 4;
  localparam int CLS_LW      = 5;
  localparam int CLS_SW      = 6;
  localparam int CLS_BEQ     = 7;
  localparam int CLS_J       = 8;
  localparam int CLS_JAL     = 9;
  localparam int CLS_ILLEGAL = 10;
  localparam int NCLS        = 11;

endpackage

// File: rtl/mc_decode.sv
// mc_decode -- combinational instruction classifier.
// Ports:
//   opcode [5:0]  IR[31:26]
//   funct  [5:0]  IR[5:0]
//   cls    [NCLS-1:0]  one-hot instruction class; CLS_ILLEGAL set for any
//                      encoding outside the supported set
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [NCLS-1:0] cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls[CLS_ADDU]    = 1'b1;
          FN_SUBU: cls[CLS_SUBU]    = 1'b1;
          FN_JR:   cls[CLS_JR]      = 1'b1;
          default: cls[CLS_ILLEGAL] = 1'b1;
        endcase
      end
      OP_ORI:  cls[CLS_ORI]     = 1'b1;
      OP_LUI:  cls[CLS_LUI]     = 1'b1;
      OP_LW:   cls[CLS_LW]      = 1'b1;
      OP_SW:   cls[CLS_SW]      = 1'b1;
      OP_BEQ:  cls[CLS_BEQ]     = 1'b1;
      OP_J:    cls[CLS_J]       = 1'b1;
      OP_JAL:  cls[CLS_JAL]     = 1'b1;
      default: cls[CLS_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle control unit for the MIPS datapath.
// Sequences FETCH/DECODE/EXE/MEM/WB and drives every datapath enable/select.
// Ports:
//   clk, reset (async, active-low)
//   opcode/funct from IR, zero from ALU, dm_ready from data memory
//   pc_we/pc_sel, ir_we, rf_we/rf_dst/rf_src, alu_src/alu_op/ext_op,
//   dm_re/dm_we memory requests, retire/illegal pulses,
//   state (debug) and instr_cnt (retired-instruction count)
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       rf_dst,
  output logic [1:0]       rf_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             dm_re,
  output logic             dm_we,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [NCLS-1:0] cls;
  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  // Ungated strobes; the outputs are masked by reset below
  logic pc_we_c, ir_we_c, rf_we_c, dm_re_c, dm_we_c, retire_c, illegal_c;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_c)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    pc_we_c    = 1'b0;
    pc_sel     = PC_SEQ;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    rf_dst     = DST_RT;
    rf_src     = SRC_ALU;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    dm_re_c    = 1'b0;
    dm_we_c    = 1'b0;
    retire_c   = 1'b0;
    illegal_c  = 1'b0;

    case (state_reg)
      S_FETCH: begin
        ir_we_c    = 1'b1;
        pc_we_c    = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        // Jumps finish here; PC already holds pc+4, which jal links into $31
        if (cls[CLS_J] || cls[CLS_JAL]) begin
          pc_we_c  = 1'b1;
          pc_sel   = PC_JMP;
          retire_c = 1'b1;
          if (cls[CLS_JAL]) begin
            rf_we_c = 1'b1;
            rf_dst  = DST_RA;
            rf_src  = SRC_PC;
          end
        end else if (cls[CLS_JR]) begin
          pc_we_c  = 1'b1;
          pc_sel   = PC_JR;
          retire_c = 1'b1;
        end else if (cls[CLS_ILLEGAL]) begin
          illegal_c = 1'b1;
        end else begin
          state_next = S_EXE;
        end
      end

      S_EXE: begin
        if (cls[CLS_ADDU] || cls[CLS_SUBU]) begin
          alu_op     = cls[CLS_SUBU] ? ALU_SUB : ALU_ADD;
          state_next = S_WB;
        end else if (cls[CLS_ORI] || cls[CLS_LUI]) begin
          alu_op     = cls[CLS_LUI] ? ALU_LUI : ALU_OR;
          alu_src    = 1'b1;
          state_next = S_WB;
        end else if (cls[CLS_LW] || cls[CLS_SW]) begin
          alu_src    = 1'b1;
          ext_op     = 1'b1;
          state_next = S_MEM;
        end else if (cls[CLS_BEQ]) begin
          alu_op   = ALU_SUB;
          ext_op   = 1'b1;
          pc_sel   = PC_BR;
          pc_we_c  = zero;
          retire_c = 1'b1;
        end
      end

      S_MEM: begin
        dm_re_c = cls[CLS_LW];
        dm_we_c = cls[CLS_SW];
        if (!dm_ready) begin
          state_next = S_MEM;
        end else if (cls[CLS_LW]) begin
          state_next = S_WB;
        end else begin
          retire_c = cls[CLS_SW];
        end
      end

      S_WB: begin
        rf_we_c  = 1'b1;
        retire_c = 1'b1;
        rf_dst   = (cls[CLS_ADDU] || cls[CLS_SUBU]) ? DST_RD : DST_RT;
        rf_src   = cls[CLS_LW] ? SRC_MDR : SRC_ALU;
      end

      default: state_next = S_FETCH;
    endcase
  end

  // While reset is low no write or pulse may escape, even combinationally
  assign pc_we     = pc_we_c   & reset;
  assign ir_we     = ir_we_c   & reset;
  assign rf_we     = rf_we_c   & reset;
  assign dm_re     = dm_re_c   & reset;
  assign dm_we     = dm_we_c   & reset;
  assign retire    = retire_c  & reset;
  assign illegal   = illegal_c & reset;
  assign state     = state_reg;
  assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- self-checking bench for mc_ctrl. Each instruction is run to
// completion and its per-instruction totals (cycles, enables, selects, pulses)
// are compared against values computed from the instruction class.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        dm_ready = 1'b1;
  logic        pc_we, ir_we, rf_we, alu_src, ext_op, dm_re, dm_we, retire, illegal;
  logic [1:0]  pc_sel, rf_dst, rf_src, alu_op;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int model_cnt = 0;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .dm_ready(dm_ready), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_src(rf_src), .alu_src(alu_src),
    .alu_op(alu_op), .ext_op(ext_op), .dm_re(dm_re), .dm_we(dm_we),
    .retire(retire), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction kinds: 0 addu 1 subu 2 jr 3 ori 4 lui 5 lw 6 sw 7 beq 8 j 9 jal 10 illegal
  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b100001) ? 0 : (fn == 6'b100011) ? 1 :
                        (fn == 6'b001000) ? 2 : 10;
      6'b001101: return 3;
      6'b001111: return 4;
      6'b100011: return 5;
      6'b101011: return 6;
      6'b000100: return 7;
      6'b000010: return 8;
      6'b000011: return 9;
      default:   return 10;
    endcase
  endfunction

  logic [5:0] t_op[10] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                           6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
  logic [5:0] t_fn[10] = '{6'b100001, 6'b100011, 6'b001000, 6'h15, 6'h2a,
                           6'h07, 6'h3c, 6'h11, 6'h01, 6'h3f};

  // Runs one instruction from FETCH until the controller is back in FETCH.
  // w = number of dm_ready-low cycles presented in MEM.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int w);
    int k = classify(op, fn);
    int cyc = 0, mem_seen = 0;
    int n_ir = 0, n_pc = 0, n_rf = 0, n_re = 0, n_we = 0, n_ret = 0, n_ill = 0;
    logic [1:0] fetch_sel = 2'd0, last_sel = 2'd0;
    logic [3:0] rf_sig = 4'd0;
    logic [3:0] exe_sig = 4'd0;
    int exp_cyc, exp_pc, exp_rf, exp_ret;
    logic [1:0] exp_sel;
    logic [3:0] exp_rfsig, exp_exe;
    opcode = op; funct = fn; zero = z;
    do begin
      dm_ready = (state == 3'd3 && mem_seen < w) ? 1'b0 : 1'b1;
      #1;
      if (ir_we) n_ir++;
      if (pc_we) begin
        n_pc++;
        if (cyc == 0) fetch_sel = pc_sel; else last_sel = pc_sel;
      end
      if (rf_we) begin n_rf++; rf_sig = {rf_dst, rf_src}; end
      if (dm_re) n_re++;
      if (dm_we) n_we++;
      if (retire) n_ret++;
      if (illegal) n_ill++;
      if (cyc == 2) exe_sig = {alu_op, alu_src, ext_op};
      if (state == 3'd3) mem_seen++;
      cyc++;
      @(negedge clk);
    end while (state != 3'd0 && cyc < 40);

    case (k)
      2, 8, 9, 10: exp_cyc = 2;
      7:           exp_cyc = 3;
      5:           exp_cyc = 5 + w;
      6:           exp_cyc = 4 + w;
      default:     exp_cyc = 4;
    endcase
    exp_pc  = 1 + ((k == 2 || k == 8 || k == 9) ? 1 : 0) + ((k == 7 && z) ? 1 : 0);
    exp_sel = (k == 8 || k == 9) ? 2'd2 : (k == 2) ? 2'd3 : (k == 7 && z) ? 2'd1 : 2'd0;
    exp_rf  = (k == 0 || k == 1 || k == 3 || k == 4 || k == 5 || k == 9) ? 1 : 0;
    case (k)
      9:       exp_rfsig = {2'd2, 2'd2};
      0, 1:    exp_rfsig = {2'd1, 2'd0};
      5:       exp_rfsig = {2'd0, 2'd1};
      default: exp_rfsig = 4'd0;
    endcase
    case (k)
      1, 7:    exp_exe = {2'd1, 1'b0, (k == 7) ? 1'b1 : 1'b0};
      3:       exp_exe = {2'd2, 1'b1, 1'b0};
      4:       exp_exe = {2'd3, 1'b1, 1'b0};
      5, 6:    exp_exe = {2'd0, 1'b1, 1'b1};
      default: exp_exe = 4'd0;
    endcase
    exp_ret = (k == 10) ? 0 : 1;
    model_cnt += exp_ret;

    check_eq("cycles", cyc, exp_cyc);
    check_eq("ir_we_cnt", n_ir, 1);
    check_eq("fetch_sel", fetch_sel, 2'd0);
    check_eq("pc_we_cnt", n_pc, exp_pc);
    check_eq("pc_sel", last_sel, exp_sel);
    check_eq("rf_we_cnt", n_rf, exp_rf);
    check_eq("rf_dst_src", rf_sig, exp_rfsig);
    if (exp_cyc > 2) check_eq("exe_ctrl", exe_sig, exp_exe);
    check_eq("dm_re_cnt", n_re, (k == 5) ? w + 1 : 0);
    check_eq("dm_we_cnt", n_we, (k == 6) ? w + 1 : 0);
    check_eq("retire_cnt", n_ret, exp_ret);
    check_eq("illegal_cnt", n_ill, (k == 10) ? 1 : 0);
    check_eq("instr_cnt", instr_cnt, model_cnt);
    $display("instr op=%b fn=%b kind=%0d zero=%0d wait=%0d cycles=%0d cnt=%0d",
             op, fn, k, z, w, cyc, instr_cnt);
  endtask

  initial begin
    // Reset held: opcode toggles must not disturb anything
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      #1;
      check_eq("rst_state", state, 3'd0);
      check_eq("rst_cnt", instr_cnt, 32'd0);
      check_eq("rst_strobes", {pc_we, ir_we, rf_we, dm_re, dm_we, retire, illegal}, 7'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rel_fetch", {ir_we, pc_we, pc_sel}, 4'b1100);

    // Directed sequence
    run_instr(6'b000000, 6'b100001, 1'b0, 0);  // addu
    run_instr(6'b100011, 6'h00, 1'b0, 2);      // lw, two wait cycles
    run_instr(6'b000100, 6'h00, 1'b1, 0);      // beq taken
    run_instr(6'b000100, 6'h00, 1'b0, 0);      // beq not taken
    run_instr(6'b000011, 6'h00, 1'b0, 0);      // jal
    run_instr(6'b111111, 6'h00, 1'b0, 0);      // illegal

    // Reset during a stalled sw in MEM
    opcode = 6'b101011; funct = 6'h00; zero = 1'b0; dm_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("sw_mem_state", state, 3'd3);
    check_eq("sw_mem_dm_we", dm_we, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("midrst_dm_we", dm_we, 1'b0);
    check_eq("midrst_state", state, 3'd0);
    check_eq("midrst_retire", retire, 1'b0);
    check_eq("midrst_cnt", instr_cnt, 32'd0);
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    dm_ready = 1'b1;
    #1;
    check_eq("midrst_fetch", {state, ir_we, pc_we}, 5'b00011);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op, fn;
      int idx;
      if ($urandom_range(0, 9) < 7) begin
        idx = $urandom_range(0, 9);
        op = t_op[idx];
        fn = t_fn[idx];
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences the PC register, instruction register, register file, ALU and data memory through FETCH/DECODE/EXE/MEM/WB states. It decodes opcode/funct from the IR and drives every write enable and mux select, including the PC's next-value select. It also counts retired instructions for the test bench.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces the block to its reset state
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- dm_ready  in  1  data memory has completed the current access
- pc_we  out  1  PC load enable
- pc_sel  out  2  next PC: 0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs (jr)
- ir_we  out  1  IR load enable
- rf_we  out  1  register file write enable
- rf_dst  out  2  write address: 0 = rt, 1 = rd, 2 = $31
- rf_src  out  2  write data: 0 = ALUOut, 1 = memory data register, 2 = PC
- alu_src  out  1  ALU B operand: 0 = rt, 1 = extended immediate
- alu_op  out  2  0 = add, 1 = sub, 2 = or, 3 = lui (imm<<16)
- ext_op  out  1  0 = zero-extend, 1 = sign-extend
- dm_re / dm_we  out  1 each  memory read / write request
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse for an unsupported encoding
- state  out  3  current state, for debug
- instr_cnt  out  CNT_W  retired-instruction count

## Operation
- Supported opcodes: R-type 000000 with funct addu 100001, subu 100011 or jr 001000; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011. Every other encoding is illegal.
- State encoding: FETCH = 0, DECODE = 1, EXE = 2, MEM = 3, WB = 4. Codes 5–7 are unreachable; if entered, go to FETCH.
- Outputs are combinational from state, opcode, funct, zero and dm_ready. Any output not listed for a state is 0.
- FETCH: ir_we = 1, pc_we = 1, pc_sel = 0. Next state DECODE.
- DECODE:
  - j: pc_we = 1, pc_sel = 2, retire.
  - jal: as j, plus rf_we = 1, rf_dst = 2, rf_src = 2. The PC already holds pc+4 at this point.
  - jr: pc_we = 1, pc_sel = 3, retire.
  - Illegal encoding: illegal = 1, no writes, no retire.
  - All four cases above return to FETCH. Every other instruction goes to EXE.
- EXE:
  - addu: alu_op = 0, alu_src = 0. subu: alu_op = 1, alu_src = 0. Both go to WB.
  - ori: alu_op = 2, alu_src = 1, ext_op = 0. lui: alu_op = 3, alu_src = 1. Both go to WB.
  - lw/sw: alu_op = 0, alu_src = 1, ext_op = 1. Go to MEM.
  - beq: alu_op = 1, alu_src = 0, ext_op = 1, pc_sel = 1, pc_we = zero, retire. Go to FETCH.
- MEM:
  - lw asserts dm_re; sw asserts dm_we. Stay in MEM while dm_ready = 0.
  - When dm_ready = 1: sw retires and goes to FETCH; lw goes to WB. The datapath captures read data on dm_re & dm_ready.
- WB: rf_we = 1, retire, next state FETCH.
  - R-type: rf_dst = 1. All other instructions: rf_dst = 0.
  - lw: rf_src = 1. All other instructions: rf_src = 0.
- instr_cnt increments by 1 on each clock edge where retire = 1. It wraps modulo 2^CNT_W.

## Timing
- Reset (reset = 0): state = FETCH and instr_cnt = 0, immediately and asynchronously. Outputs are the FETCH decode only after reset returns to 1; while reset = 0, all strobes (pc_we, ir_we, rf_we, dm_re, dm_we, retire, illegal) are forced to 0.
- Reset asserted mid-instruction abandons that instruction. It is not retired and no further writes are issued.
- Cycles per instruction with zero memory wait: j/jal/jr 2, beq 3, addu/subu/ori/lui/sw 4, lw 5. Each cycle of dm_ready = 0 in MEM adds one cycle.
- An illegal instruction takes 2 cycles: illegal pulses in its DECODE cycle.
- dm_re/dm_we stay high continuously from MEM entry until the dm_ready cycle, inclusive.

## Structure
- Shared package mc_pkg: opcode and funct constants, the state enum, and the pc_sel/rf_dst/rf_src/alu_op codes. The npc and ALU muxes use the same package.
- One sub-module, mc_decode: combinational opcode/funct to instruction-class one-hot, including the illegal flag. The FSM and counter stay in mc_ctrl.

## Test plan
- Reset: hold reset low, toggle opcode -> state = 0, instr_cnt = 0, all strobes 0. Release reset -> ir_we = 1, pc_we = 1, pc_sel = 0 in the first cycle.
- addu (funct 100001) then lw with dm_ready low for 2 cycles -> addu takes 4 cycles with rf_dst = 1 in WB. lw takes 7 cycles with dm_re high for 3 cycles and rf_src = 1 in WB. instr_cnt = 2.
- beq with zero = 1 then with zero = 0 -> pc_we = 1/pc_sel = 1 in the first EXE, pc_we = 0 in the second. Each takes 3 cycles and retires.
- jal -> DECODE cycle has pc_sel = 2, rf_we = 1, rf_dst = 2, rf_src = 2, retire = 1; back in FETCH on the next cycle.
- opcode 111111 -> illegal pulses exactly once, instr_cnt unchanged, FETCH follows.
- Reset asserted during MEM of sw with dm_ready = 0 -> dm_we drops to 0 at once, state = 0, no retire; normal FETCH after release.
